// File: rtl/disp_pkg.sv
// Shared encodings for the two-digit display path: page ids, scheduling modes
// and where the displayed data bytes sit inside the processor packet.
package disp_pkg;

  typedef enum logic [1:0] {
    PG_PC = 2'd0,
    PG_B0 = 2'd1,
    PG_B1 = 2'd2,
    PG_B2 = 2'd3
  } page_e;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  localparam int PC_W  = 5;
  localparam int PKT_W = 38;

  // Packet byte offsets: data low byte, data high byte, third byte.
  localparam int PKT_B0_LSB = 0;
  localparam int PKT_B1_LSB = 8;
  localparam int PKT_B2_LSB = 16;

  function automatic logic [3:0] pick_nibble(input logic [7:0] byte_v, input logic hi);
    return hi ? byte_v[7:4] : byte_v[3:0];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push button -> 2-FF synchroniser -> debouncer sampled on tick_i ->
// one-cycle pulse on an accepted 0->1 transition of the stable level.
module btn_debounce #(
  parameter int DEB_TICKS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic btn_async_i,
  output logic press_o
);

  localparam int CW = $clog2(DEB_TICKS + 1);

  logic          sync1_q, sync2_q;
  logic          cand_q, cand_d;
  logic          stable_q, stable_d;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // cand_q is the level currently being counted; it becomes stable once it
  // has been seen on DEB_TICKS consecutive ticks.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (tick_i) begin
      if (sync2_q != cand_q) begin
        cand_d = sync2_q;
        cnt_d  = CW'(1);
      end else if (cnt_q < CW'(DEB_TICKS)) begin
        cnt_d = cnt_q + CW'(1);
      end
      if (cnt_d >= CW'(DEB_TICKS)) stable_d = cand_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cand_q   <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_async_i;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= stable_d & ~stable_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/disp_page_sched.sv
// Two-digit display controller: packet snapshot capture, page scheduling
// (manual button or dwell-timed rotation) and digit/nibble multiplexing.
module disp_page_sched
  import disp_pkg::*;
#(
  parameter int SCAN_DIV    = 250000,
  parameter int DWELL_TICKS = 100,
  parameter int DEB_TICKS   = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [PC_W-1:0]  PC,
  input  logic [PKT_W-1:0] PKT_IN,
  input  logic             PKT_VALID,
  output logic             PKT_READY,
  input  logic             FREEZE,
  input  logic             MODE,
  input  logic             BTN_NEXT,
  output logic             TOGLE,
  output logic [3:0]       NIBBLE,
  output logic [1:0]       PAGE,
  output logic             NEW_PKT
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

  logic [SW-1:0]    scan_cnt_q, scan_cnt_d;
  logic             togle_q, togle_d;
  logic             ready_q, ready_d;
  logic [PKT_W-1:0] snap_q, snap_d;
  logic             newp_q, newp_d;
  logic             req_q, req_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  page_e            page_q, page_d;
  mode_e            state_q, state_d;

  logic       scan_tick, capture, btn_press, dwell_exp, adv_want, apply;
  logic [7:0] byte_sel;
  logic       snap_hi_unused;

  btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_btn_next (
    .clk         (CLK),
    .rst_n       (RST_N),
    .tick_i      (scan_tick),
    .btn_async_i (BTN_NEXT),
    .press_o     (btn_press)
  );

  // Handshake: a packet transfers on any cycle where PKT_VALID and PKT_READY
  // are both high. READY is the registered inverse of FREEZE, so a transfer in
  // the cycle FREEZE rises still lands and READY drops on the following cycle.
  always_comb begin
    scan_tick  = (scan_cnt_q == SW'(SCAN_DIV - 1));
    scan_cnt_d = scan_tick ? '0 : scan_cnt_q + SW'(1);
    togle_d    = togle_q ^ scan_tick;
    ready_d    = ~FREEZE;
    capture    = PKT_VALID & ready_q;
    snap_d     = capture ? PKT_IN : snap_q;
    state_d    = mode_e'(MODE);

    dwell_d   = dwell_q;
    dwell_exp = 1'b0;
    if (state_q == MODE_AUTO) begin
      if (btn_press) begin
        dwell_d = '0;
      end else if (scan_tick) begin
        if (dwell_q == DW'(DWELL_TICKS - 1)) begin
          dwell_exp = 1'b1;
          dwell_d   = '0;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
    end else begin
      dwell_d = '0;
    end

    // Page changes only land on the tick that returns to the low digit.
    adv_want = req_q | btn_press | dwell_exp;
    apply    = scan_tick & ~togle_d & adv_want;
    page_d   = apply ? page_e'(page_q + 2'd1) : page_q;
    req_d    = adv_want & ~apply;

    if (capture)                       newp_d = 1'b1;
    else if (apply && page_d != PG_PC) newp_d = 1'b0;
    else                               newp_d = newp_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scan_cnt_q <= '0;
      togle_q    <= 1'b0;
      ready_q    <= 1'b0;
      snap_q     <= '0;
      newp_q     <= 1'b0;
      req_q      <= 1'b0;
      dwell_q    <= '0;
      page_q     <= PG_PC;
      state_q    <= MODE_MANUAL;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      togle_q    <= togle_d;
      ready_q    <= ready_d;
      snap_q     <= snap_d;
      newp_q     <= newp_d;
      req_q      <= req_d;
      dwell_q    <= dwell_d;
      page_q     <= page_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    case (page_q)
      PG_PC:   byte_sel = {3'b000, PC};
      PG_B0:   byte_sel = snap_q[PKT_B0_LSB +: 8];
      PG_B1:   byte_sel = snap_q[PKT_B1_LSB +: 8];
      PG_B2:   byte_sel = snap_q[PKT_B2_LSB +: 8];
      default: byte_sel = 8'h00;
    endcase
  end

  // Upper packet fields are captured with the snapshot but never displayed.
  assign snap_hi_unused = ^snap_q[PKT_W-1:24];

  assign NIBBLE    = pick_nibble(byte_sel, togle_q);
  assign TOGLE     = togle_q;
  assign PAGE      = page_q;
  assign NEW_PKT   = newp_q;
  assign PKT_READY = ready_q;

endmodule
